ahb_burst_master: RTL
=====================

// Module: ahb_burst_master
// PURPOSE
//  Bus-side initiator for one AHB master slot; the requesting end of the arbiter's Hbusreq/Hgrant loop.
//  Accepts one burst command from local logic and raises Hbusreq until Hgrant.
//  Drives pipelined NONSEQ/SEQ address phases and moves write/read data beats.
//  Handles wait states, grant loss (INCR only) and ERROR responses.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width; beat size BYTES=DATA_W/8, Hsize=log2(BYTES), fixed for all beats
// PORTS
//  Hclk       in   1       clock
//  Hresetn    in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1       1=write burst, 0=read burst
//  cmd_addr   in   ADDR_W  start address, BYTES-aligned
//  cmd_burst  in   3       AHB Hburst code
//  cmd_len    in   5       beat count for INCR (001), 1..16; ignored for fixed bursts
//  wr_data    in   DATA_W  next write beat; consumed on wr_pop
//  wr_pop     out  1       pulse: wr_data captured into Hwdata
//  rd_data    out  DATA_W  read beat
//  rd_valid   out  1       pulse: rd_data valid
//  done       out  1       1-cycle pulse: burst finished (ok or error)
//  err        out  1       qualifies done: burst ended by ERROR
//  Hbusreq    out  1       bus request to arbiter
//  Hgrant     in   1       this master's grant bit
//  Hready     in   1       global transfer-done
//  Hresp      in   1       1=ERROR on the completing data phase
//  Hrdata     in   DATA_W  read data
//  Haddr Htrans Hwrite Hsize Hburst Hwdata  out  AHB address/control/write-data
// BEHAVIOUR
//  Reset: FSM=IDLE; cmd_ready=1; Hbusreq, wr_pop, rd_valid, done, err = 0.
//   Htrans=IDLE(00); Haddr, Hwdata, rd_data = 0; Hwrite=0; Hburst=000; Hsize=log2(BYTES).
//  Beats: SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16; INCR=cmd_len.
//   cmd_len=0 is treated as 1.
//  FSM IDLE->REQ on cmd accept: latch command, cmd_ready=0, Hbusreq=1 the next cycle.
//  REQ->ADDR at an edge with Hgrant&&Hready: the next cycle drives NONSEQ with start Haddr.
//  ADDR/BURST: an address phase is accepted at an edge with Hready=1.
//   On acceptance, advance Haddr and drive SEQ for the next beat.
//   Hready=0: hold Haddr/Htrans/Hwrite/Hwdata stable.
//  Address step: INCR*: Haddr+BYTES (ADDR_W wrap-around, no 1KB check).
//   WRAP: mask=beats*BYTES-1; next = (Haddr & ~mask) | ((Haddr+BYTES) & mask).
//   Example: WRAP4 0x38 -> 0x3C, 0x30, 0x34.
//  Hbusreq deasserts on acceptance of the last address phase.
//   Htrans=IDLE afterwards; FSM enters LAST, waits the final data phase, then goes to IDLE.
//  Write data: on each write address acceptance, wr_pop=1 for that cycle.
//   Hwdata<=wr_data at the same edge and is held through the data phase.
//  Read data: the data phase completes when Hready=1; rd_valid=1 and rd_data=Hrdata the next cycle.
//  done pulses 1 cycle after the last data phase completes; cmd_ready=1 in that same cycle.
//  Grant loss (Hgrant=0 at an acceptance edge, INCR only):
//   Remaining beats drive IDLE; FSM returns to REQ with Hbusreq held.
//   On regrant, resume with NONSEQ at the next un-issued address.
//   Beats already accepted still complete their data phase.
//  Grant loss during fixed-length bursts is a protocol violation; behaviour is unspecified.
//  ERROR: a data phase completing with Hresp=1 aborts the burst:
//   Htrans=IDLE next cycle, Hbusreq=0, no further wr_pop; a pipelined read beat does not assert rd_valid.
//   done=1, err=1 the following cycle.
//  Simultaneous events: a command offered during done is accepted (cmd_ready=1); a new REQ starts the next cycle.
//  Reset mid-burst: immediate return to reset values; no done is issued.
// TESTING
//  Reset mid-burst -> Htrans=00, Hbusreq=0, cmd_ready=1 asynchronously; no done.
//  INCR4 write at 0x100, Hready=1 -> Haddr 100/104/108/10C; Htrans 10,11,11,11; 4 wr_pop; one done.
//  WRAP4 read at 0x38 with Hready low 2 cycles on beat 2 -> Haddr 38,3C,30,34; controls held; 4 rd_valid in order.
//  INCR len=6 at 0x0, Hgrant drops after beat 3 accepted -> IDLE; regrant -> NONSEQ 0xC, SEQ 0x10, 0x14.
//  INCR8 read, Hresp=1 on beat 3 -> Htrans IDLE next cycle, Hbusreq=0; done=err=1; exactly 2 rd_valid.
//  SINGLE write, grant withheld 5 cycles -> Hbusreq held high, Htrans=IDLE until grant; then one NONSEQ beat and done.

Source files
------------

// File: rtl/ahb_burst_master.sv
// AHB master slot initiator: requests the bus for one burst command, drives
// pipelined NONSEQ/SEQ address phases and moves write/read data beats.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [4:0]        cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              Hbusreq,
    input  logic              Hgrant,
    input  logic              Hready,
    input  logic              Hresp,
    input  logic [DATA_W-1:0] Hrdata,
    output logic [ADDR_W-1:0] Haddr,
    output logic [1:0]        Htrans,
    output logic              Hwrite,
    output logic [2:0]        Hsize,
    output logic [2:0]        Hburst,
    output logic [DATA_W-1:0] Hwdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_INCR   = 3'b001;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_LAST, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [4:0]        beats;     // total beats, sizes the wrap window
    logic [4:0]        rem;       // address phases still to be accepted
    logic              is_seq;
    logic              dp_valid;  // a data phase of ours is on the bus
    logic              addr_acc, dp_done, err_hit, last_beat, is_wrap;
    logic [ADDR_W-1:0] inc_addr, wrap_mask, next_addr;

    function automatic logic [4:0] beats_of(input logic [2:0] burst, input logic [4:0] len);
        logic [4:0] n;
        n = 5'd16;
        case (burst)
            3'b000:         n = 5'd1;
            3'b001:         n = (len == 5'd0) ? 5'd1 : len;
            3'b010, 3'b011: n = 5'd4;
            3'b100, 3'b101: n = 5'd8;
            default:        n = 5'd16;
        endcase
        return n;
    endfunction

    assign Hsize     = 3'(SIZE);
    assign addr_acc  = (state == S_ADDR) && Hready;
    assign dp_done   = dp_valid && Hready;
    assign err_hit   = dp_done && Hresp;
    assign last_beat = (rem == 5'd1);
    assign is_wrap   = (Hburst != 3'b000) && !Hburst[0];
    assign inc_addr  = Haddr + ADDR_W'(BYTES);
    assign wrap_mask = (ADDR_W'(beats) << SIZE) - ADDR_W'(1);
    assign next_addr = is_wrap ? ((Haddr & ~wrap_mask) | (inc_addr & wrap_mask)) : inc_addr;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first, so no path through this block leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = S_REQ;
            S_REQ: begin
                if (err_hit)               state_nxt = S_ERR;
                else if (Hgrant && Hready) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (err_hit)                            state_nxt = S_ERR;
                else if (Hready && last_beat)           state_nxt = S_LAST;
                else if (Hready && Hburst == B_INCR && !Hgrant) state_nxt = S_REQ;
            end
            S_LAST: begin
                if (err_hit)     state_nxt = S_ERR;
                else if (Hready) state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        Hbusreq   = (state == S_REQ) || (state == S_ADDR);
        Htrans    = T_IDLE;
        if (state == S_ADDR) Htrans = is_seq ? T_SEQ : T_NONSEQ;
        // A beat pipelined behind an ERROR is abandoned, so its data is not taken.
        wr_pop    = addr_acc && Hwrite && !err_hit;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr    <= '0;
            Hwrite   <= 1'b0;
            Hburst   <= 3'b000;
            Hwdata   <= '0;
            beats    <= 5'd0;
            rem      <= 5'd0;
            is_seq   <= 1'b0;
            dp_valid <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values regardless of statement order.
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (state == S_IDLE && cmd_valid) begin
                Haddr  <= cmd_addr;
                Hwrite <= cmd_write;
                Hburst <= cmd_burst;
                beats  <= beats_of(cmd_burst, cmd_len);
                rem    <= beats_of(cmd_burst, cmd_len);
            end
            if (state == S_REQ && Hgrant && Hready) is_seq <= 1'b0;
            if (addr_acc && !err_hit) begin
                Haddr  <= next_addr;
                rem    <= rem - 5'd1;
                is_seq <= 1'b1;
            end
            if (wr_pop) Hwdata <= wr_data;
            if (Hready) dp_valid <= addr_acc && !err_hit;
            if (dp_done && !Hresp && !Hwrite) begin
                rd_valid <= 1'b1;
                rd_data  <= Hrdata;
            end
            if ((state == S_LAST && Hready && !Hresp) || state == S_ERR) done <= 1'b1;
            if (state == S_ERR) err <= 1'b1;
        end
    end

endmodule
